// File: rtl/run_length_detector_if.sv
// run_length_detector_if: sample/control inputs and run-status outputs of the run-length detector
interface run_length_detector_if #(
    parameter int LEN_W = 4,
    parameter int DET_W = 8
);
    logic             en;
    logic             clr;
    logic             w;
    logic             z;
    logic             det_pulse;
    logic             run_bit;
    logic [LEN_W-1:0] run_len;
    logic [DET_W-1:0] det_count;

    modport master (output en, clr, w, input z, det_pulse, run_bit, run_len, det_count);
    modport slave  (input en, clr, w, output z, det_pulse, run_bit, run_len, det_count);
endinterface

// File: rtl/run_length_detector.sv
// run_length_detector: tracks the current run of identical bits on w; z while run_len == RUN_LEN; non-overlapping mode via RUN_DET_NONOVERLAP_EN
module run_length_detector #(
    parameter int RUN_LEN = 4,
    parameter int LEN_W   = 4,
    parameter int DET_W   = 8
) (
    input logic                Clock,
    input logic                Resetn,
    run_length_detector_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN0 = 2'd1, RUN1 = 2'd2} state_t;

    localparam logic [LEN_W-1:0] FULL = LEN_W'(RUN_LEN);

    state_t           state;
    logic [LEN_W-1:0] len;
    logic             bit_q;
    logic             z_q;
    logic             pulse_q;
    logic [DET_W-1:0] cnt;
    logic             same;
    logic             extend;
    logic [LEN_W-1:0] next_len;
    logic             hit;

    assign same = (state != IDLE) && (bus.w == bit_q);
`ifdef RUN_DET_NONOVERLAP_EN
    // A completed run is consumed by its detection, so the next sample always starts over.
    assign extend = same && !z_q;
`else
    assign extend = same;
`endif
    assign next_len = !extend ? LEN_W'(1) : (len == FULL ? FULL : len + LEN_W'(1));
    assign hit      = (next_len == FULL) && !z_q;

    assign bus.z         = z_q;
    assign bus.det_pulse = pulse_q;
    assign bus.run_bit   = bit_q;
    assign bus.run_len   = len;
    assign bus.det_count = cnt;

    // Run-tracking FSM with registered outputs; clr beats en, illegal encodings fall back to IDLE.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn || bus.clr) begin
            state   <= IDLE;
            len     <= '0;
            bit_q   <= 1'b0;
            z_q     <= 1'b0;
            pulse_q <= 1'b0;
            cnt     <= '0;
        end else begin
            pulse_q <= 1'b0;
            case (state)
                IDLE, RUN0, RUN1: begin
                    if (bus.en) begin
                        state   <= bus.w ? RUN1 : RUN0;
                        bit_q   <= bus.w;
                        len     <= next_len;
                        z_q     <= next_len == FULL;
                        pulse_q <= hit;
                        if (hit && cnt != '1)
                            cnt <= cnt + DET_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    len   <= '0;
                    bit_q <= 1'b0;
                    z_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: random + directed check of run_length_detector against a run-counting model
module tb_run_length_detector;
    localparam int RL = 4;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic w = 1'b0;
    bit   chk_on = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 Clock = ~Clock;

    run_length_detector_if #(.LEN_W(4), .DET_W(8)) b1 ();
    run_length_detector_if #(.LEN_W(4), .DET_W(2)) b2 ();

    assign b1.en = en;
    assign b1.clr = clr;
    assign b1.w = w;
    assign b2.en = en;
    assign b2.clr = clr;
    assign b2.w = w;

    run_length_detector #(.RUN_LEN(RL), .LEN_W(4), .DET_W(8)) dut1 (.Clock(Clock), .Resetn(Resetn), .bus(b1.slave));
    run_length_detector #(.RUN_LEN(RL), .LEN_W(4), .DET_W(2)) dut2 (.Clock(Clock), .Resetn(Resetn), .bus(b2.slave));

    // Model: unbounded count of identical samples since the last bit change
    int   m_cnt = 0;
    logic m_bit = 1'b0;
    bit   m_idle = 1'b1;
    bit   m_pulse = 1'b0;
    int   m_det1 = 0;
    int   m_det2 = 0;

    task automatic model_reset();
        m_idle = 1'b1; m_cnt = 0; m_bit = 1'b0; m_pulse = 1'b0; m_det1 = 0; m_det2 = 0;
    endtask

    task automatic model_step(input logic e, input logic c, input logic wi);
        bit det;
        if (c) begin
            model_reset();
        end else begin
            m_pulse = 1'b0;
            if (e) begin
                if (m_idle || wi != m_bit) begin
                    m_cnt = 1; m_bit = wi; m_idle = 1'b0;
                end else begin
                    m_cnt++;
                end
`ifdef RUN_DET_NONOVERLAP_EN
                det = (m_cnt % RL) == 0;
`else
                det = m_cnt == RL;
`endif
                if (det) begin
                    m_pulse = 1'b1;
                    m_det1 = (m_det1 + 1 > 255) ? 255 : m_det1 + 1;
                    m_det2 = (m_det2 + 1 > 3) ? 3 : m_det2 + 1;
                end
            end
        end
    endtask

    function automatic int exp_len();
        if (m_idle) return 0;
`ifdef RUN_DET_NONOVERLAP_EN
        return (m_cnt - 1) % RL + 1;
`else
        return (m_cnt < RL) ? m_cnt : RL;
`endif
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic wi);
        en = e; clr = c; w = wi;
        @(posedge Clock);
        if (Resetn) model_step(e, c, wi);
        @(negedge Clock);
    endtask

    // Compare both DUTs against the model every cycle
    always @(negedge Clock) begin : compare
        int l;
        if (chk_on) begin
            l = exp_len();
            cmp("z1", 32'(b1.z), 32'(l == RL));
            cmp("pulse1", 32'(b1.det_pulse), 32'(m_pulse));
            cmp("bit1", 32'(b1.run_bit), 32'(m_idle ? 1'b0 : m_bit));
            cmp("len1", 32'(b1.run_len), 32'(l));
            cmp("cnt1", 32'(b1.det_count), 32'(m_det1));
            cmp("z2", 32'(b2.z), 32'(l == RL));
            cmp("pulse2", 32'(b2.det_pulse), 32'(m_pulse));
            cmp("len2", 32'(b2.run_len), 32'(l));
            cmp("cnt2", 32'(b2.det_count), 32'(m_det2));
        end
    end

    initial begin
        int t3[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic wr;
        model_reset();
        // 1: reset held with w toggling
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, k[0]);
        chk_on = 1'b1;
        cmp("t1_z", 32'(b1.z), 0);
        cmp("t1_pulse", 32'(b1.det_pulse), 0);
        cmp("t1_len", 32'(b1.run_len), 0);
        cmp("t1_cnt", 32'(b1.det_count), 0);
        Resetn = 1'b1;
        // 2: four 1s detect, then run continues
        repeat (4) step(1'b1, 1'b0, 1'b1);
        cmp("t2_z", 32'(b1.z), 1);
        cmp("t2_pulse", 32'(b1.det_pulse), 1);
        cmp("t2_cnt", 32'(b1.det_count), 1);
        cmp("t2_len", 32'(b1.run_len), 4);
        step(1'b1, 1'b0, 1'b1);
        cmp("t2_pulse_drop", 32'(b1.det_pulse), 0);
`ifdef RUN_DET_NONOVERLAP_EN
        cmp("t2_restart_len", 32'(b1.run_len), 1);
        cmp("t2_restart_z", 32'(b1.z), 0);
`else
        repeat (2) step(1'b1, 1'b0, 1'b1);
        cmp("t2_hold_z", 32'(b1.z), 1);
        cmp("t2_hold_cnt", 32'(b1.det_count), 1);
        cmp("t2_hold_len", 32'(b1.run_len), 4);
`endif
        step(1'b1, 1'b1, 1'b0);
        cmp("t2_clr_len", 32'(b1.run_len), 0);
        cmp("t2_clr_cnt", 32'(b1.det_count), 0);
        // 3: broken run then four 0s
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, t3[k][0]);
        cmp("t3_z7", 32'(b1.z), 0);
        step(1'b1, 1'b0, t3[7][0]);
        cmp("t3_z8", 32'(b1.z), 1);
        cmp("t3_bit", 32'(b1.run_bit), 0);
        cmp("t3_cnt", 32'(b1.det_count), 1);
        step(1'b1, 1'b1, 1'b0);
        // 4: en=0 gaps do not count
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        cmp("t4_hold_len", 32'(b1.run_len), 2);
        cmp("t4_hold_z", 32'(b1.z), 0);
        step(1'b1, 1'b0, 1'b1);
        cmp("t4_z3", 32'(b1.z), 0);
        step(1'b1, 1'b0, 1'b1);
        cmp("t4_z4", 32'(b1.z), 1);
        cmp("t4_pulse", 32'(b1.det_pulse), 1);
        step(1'b0, 1'b0, 1'b0);
        cmp("t4_pulse_en0", 32'(b1.det_pulse), 0);
        cmp("t4_z_en0", 32'(b1.z), 1);
        // 5: clr with en=0 mid-run, then async reset mid-run
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        cmp("t5_len3", 32'(b1.run_len), 3);
        step(1'b0, 1'b1, 1'b1);
        cmp("t5_clr_len", 32'(b1.run_len), 0);
        cmp("t5_clr_cnt", 32'(b1.det_count), 0);
        cmp("t5_clr_z", 32'(b1.z), 0);
        repeat (4) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1);
        #2 Resetn = 1'b0;
        model_reset();
        #1;
        cmp("t5_rst_len", 32'(b1.run_len), 0);
        cmp("t5_rst_cnt", 32'(b1.det_count), 0);
        cmp("t5_rst_z", 32'(b1.z), 0);
        @(negedge Clock);
        Resetn = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        cmp("t5_fresh_len", 32'(b1.run_len), 1);
        cmp("t5_fresh_bit", 32'(b1.run_bit), 1);
        // 6: five detections, 2-bit counter saturates
        step(1'b1, 1'b1, 1'b0);
        repeat (5) begin
            repeat (4) step(1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0);
        end
        cmp("t6_cnt8", 32'(b1.det_count), 5);
        cmp("t6_cnt2", 32'(b2.det_count), 3);
        cmp("t6_model", 32'(m_det1), 5);
`ifdef RUN_DET_NONOVERLAP_EN
        step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b1);
        cmp("t6_no_p4", 32'(b1.det_pulse), 1);
        repeat (4) step(1'b1, 1'b0, 1'b1);
        cmp("t6_no_p8", 32'(b1.det_pulse), 1);
        cmp("t6_no_cnt", 32'(b1.det_count), 2);
`endif
        // Random phase
        wr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                #2 Resetn = 1'b0;
                model_reset();
                #1 Resetn = 1'b1;
            end else begin
                if ($urandom_range(0, 3) == 0) wr = ~wr;
                step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0, wr);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
